// File: rtl/conv_seq_pkg.sv
// Shared types and register packing helpers for the convolution layer sequencer.
// Imported by the sequencer top and its planner.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_START,
        ST_RUN,
        ST_CHECK
    } seq_state_e;

    localparam int unsigned BCFG1_ENG_LSB    = 0;
    localparam int unsigned BCFG1_ENG_W      = 8;
    localparam int unsigned BCFG1_SHIFT_LSB  = 8;
    localparam int unsigned BCFG1_SHIFT_W    = 4;
    localparam int unsigned CPRM1_STRIDE_LSB = 6;
    localparam int unsigned CPRM1_STRIDE_W   = 4;

    function automatic logic [15:0] pack_bcfg1(input logic [BCFG1_ENG_W-1:0] engines,
                                               input logic [BCFG1_SHIFT_W-1:0] shift);
        logic [15:0] r;
        r = '0;
        r[BCFG1_ENG_LSB +: BCFG1_ENG_W]     = engines;
        r[BCFG1_SHIFT_LSB +: BCFG1_SHIFT_W] = shift;
        return r;
    endfunction

    function automatic logic [15:0] pack_cprm1(input logic [CPRM1_STRIDE_W-1:0] stride);
        logic [15:0] r;
        r = '0;
        r[CPRM1_STRIDE_LSB +: CPRM1_STRIDE_W] = stride;
        return r;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Layer command handshake between the network command path and the sequencer.
// The command path drives the master side; the sequencer takes the slave side.
interface conv_layer_sequencer_if #(
    parameter int unsigned MaxFilters = 64
);
    localparam int unsigned FilterW = $clog2(MaxFilters + 1);

    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [15:0]        cmd_matrix_size_i;
    logic [FilterW-1:0] cmd_filters_i;
    logic [1:0]         cmd_stride_log2_i;
    logic [3:0]         cmd_shift_i;

    modport master (
        output cmd_valid_i,
        output cmd_matrix_size_i,
        output cmd_filters_i,
        output cmd_stride_log2_i,
        output cmd_shift_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_matrix_size_i,
        input  cmd_filters_i,
        input  cmd_stride_log2_i,
        input  cmd_shift_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/conv_seq_planner.sv
// Derives group count G, last-group engine count A and expected output beats N
// from a layer command.
module conv_seq_planner #(
    parameter int unsigned EngineCount = 2,
    parameter int unsigned KernelSize  = 3,
    parameter int unsigned FilterW     = 7,
    parameter int unsigned GroupW      = 6
) (
    input  logic [15:0]        matrix_size_i,
    input  logic [FilterW-1:0] filters_i,
    input  logic [1:0]         stride_log2_i,
    output logic [GroupW-1:0]  groups_o,
    output logic [7:0]         last_engines_o,
    output logic [31:0]        beats_o
);
    logic [31:0] filt_w;
    logic [31:0] grp_w;
    logic [31:0] last_w;
    logic [31:0] side_w;
    logic [31:0] beats_w;

    always_comb begin
        filt_w  = 32'(filters_i);
        grp_w   = (filt_w + EngineCount - 32'd1) / EngineCount;
        last_w  = '0;
        side_w  = '0;
        beats_w = '0;
        if (grp_w != '0) begin
            last_w = filt_w - (grp_w - 32'd1) * EngineCount;
        end
        // An undersized input yields no valid output positions.
        if (32'(matrix_size_i) >= KernelSize) begin
            side_w  = (32'(matrix_size_i) - KernelSize) >> stride_log2_i;
            beats_w = (side_w + 32'd1) * (side_w + 32'd1);
        end
        groups_o       = GroupW'(grp_w);
        last_engines_o = 8'(last_w);
        beats_o        = beats_w;
    end
endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one convolution layer on convolution_layer in engine-sized filter groups:
// reset, program, start, count beats, check, advance.
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned EngineCount   = 2,
    parameter int unsigned KernelSize    = 3,
    parameter int unsigned MaxMatrixSize = 10,
    parameter int unsigned MaxFilters    = 64,
    localparam int unsigned FilterW      = $clog2(MaxFilters + 1),
    localparam int unsigned MaxGroups    = (MaxFilters + EngineCount - 1) / EngineCount,
    localparam int unsigned BankW        = (MaxGroups > 1) ? $clog2(MaxGroups) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    conv_layer_sequencer_if.slave cmd,
    input  logic                  abort_i,
    output logic                  conv_rst_o,
    output logic                  conv_start_o,
    output logic [15:0]           reg_bcfg1_o,
    output logic [15:0]           reg_bcfg2_o,
    output logic [15:0]           reg_cprm1_o,
    output logic [BankW-1:0]      weight_bank_o,
    input  logic                  conv_valid_i,
    input  logic                  conv_done_i,
    output logic                  group_done_o,
    output logic                  layer_done_o,
    output logic                  err_o
);
    localparam int unsigned GroupW  = $clog2(MaxGroups + 1);
    localparam int unsigned MaxSide = MaxMatrixSize - KernelSize + 1;
    localparam int unsigned CntW    = $clog2(MaxSide * MaxSide + 1);

    seq_state_e         state_q;
    logic [BankW-1:0]   group_q;
    logic [CntW-1:0]    cnt_q;
    logic [15:0]        matrix_q;
    logic [FilterW-1:0] filters_q;
    logic [1:0]         stride_q;
    logic [3:0]         shift_q;
    logic               err_q;
    logic               rst_q;
    logic               start_q;
    logic               gdone_q;
    logic               ldone_q;
    logic               ready_q;
    logic [15:0]        bcfg1_q;
    logic [15:0]        bcfg2_q;
    logic [15:0]        cprm1_q;
    logic [BankW-1:0]   bank_q;

    logic [15:0]        plan_m;
    logic [FilterW-1:0] plan_f;
    logic [1:0]         plan_s;
    logic [GroupW-1:0]  groups;
    logic [7:0]         last_eng;
    logic [31:0]        beats;

    logic               accept;
    logic [CntW-1:0]    cnt_inc;
    logic               is_last;
    logic               next_is_last;
    logic [7:0]         eng_first;
    logic [7:0]         eng_next;
    logic [3:0]         stride_val;

    // In IDLE the planner sees the incoming command so group 0 can be programmed on accept.
    always_comb begin
        plan_m = matrix_q;
        plan_f = filters_q;
        plan_s = stride_q;
        if (state_q == ST_IDLE) begin
            plan_m = cmd.cmd_matrix_size_i;
            plan_f = cmd.cmd_filters_i;
            plan_s = cmd.cmd_stride_log2_i;
        end
    end

    conv_seq_planner #(
        .EngineCount (EngineCount),
        .KernelSize  (KernelSize),
        .FilterW     (FilterW),
        .GroupW      (GroupW)
    ) u_planner (
        .matrix_size_i  (plan_m),
        .filters_i      (plan_f),
        .stride_log2_i  (plan_s),
        .groups_o       (groups),
        .last_engines_o (last_eng),
        .beats_o        (beats)
    );

    always_comb begin
        accept       = cmd.cmd_valid_i && ready_q;
        cnt_inc      = cnt_q;
        if (conv_valid_i && (cnt_q != '1)) begin
            cnt_inc = cnt_q + CntW'(1);
        end
        is_last      = (32'(group_q) + 32'd1) >= 32'(groups);
        next_is_last = (32'(group_q) + 32'd2) >= 32'(groups);
        eng_first    = (32'(groups) <= 32'd1) ? last_eng : 8'(EngineCount);
        eng_next     = next_is_last ? last_eng : 8'(EngineCount);
        stride_val   = 4'd1 << cmd.cmd_stride_log2_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            group_q   <= '0;
            cnt_q     <= '0;
            matrix_q  <= '0;
            filters_q <= '0;
            stride_q  <= '0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            rst_q     <= 1'b0;
            start_q   <= 1'b0;
            gdone_q   <= 1'b0;
            ldone_q   <= 1'b0;
            ready_q   <= 1'b1;
            bcfg1_q   <= '0;
            bcfg2_q   <= '0;
            cprm1_q   <= '0;
            bank_q    <= '0;
        end else begin
            rst_q   <= 1'b0;
            start_q <= 1'b0;
            gdone_q <= 1'b0;
            ldone_q <= 1'b0;
            if (abort_i && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                rst_q   <= 1'b1;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            matrix_q  <= cmd.cmd_matrix_size_i;
                            filters_q <= cmd.cmd_filters_i;
                            stride_q  <= cmd.cmd_stride_log2_i;
                            shift_q   <= cmd.cmd_shift_i;
                            group_q   <= '0;
                            bank_q    <= '0;
                            err_q     <= 1'b0;
                            bcfg1_q   <= pack_bcfg1(eng_first, cmd.cmd_shift_i);
                            bcfg2_q   <= cmd.cmd_matrix_size_i;
                            cprm1_q   <= pack_cprm1(stride_val);
                            rst_q     <= 1'b1;
                            ready_q   <= 1'b0;
                            state_q   <= ST_RST;
                        end
                    end
                    ST_RST: begin
                        start_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end
                    ST_START: begin
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        cnt_q <= cnt_inc;
                        // Decide err and the done pulses here so they appear during CHECK.
                        if (conv_done_i) begin
                            if (32'(cnt_inc) != beats) begin
                                err_q <= 1'b1;
                            end
                            gdone_q <= 1'b1;
                            ldone_q <= is_last;
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (is_last) begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            group_q <= group_q + BankW'(1);
                            bank_q  <= group_q + BankW'(1);
                            bcfg1_q <= pack_bcfg1(eng_next, shift_q);
                            rst_q   <= 1'b1;
                            state_q <= ST_RST;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cmd.cmd_ready_o = ready_q;
    assign conv_rst_o      = rst_q;
    assign conv_start_o    = start_q;
    assign reg_bcfg1_o     = bcfg1_q;
    assign reg_bcfg2_o     = bcfg2_q;
    assign reg_cprm1_o     = cprm1_q;
    assign weight_bank_o   = bank_q;
    assign group_done_o    = gdone_q;
    assign layer_done_o    = ldone_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a stub layer driven from the stimulus.
// Expected register values and pulse counts are hand-computed constants.
module tb_conv_layer_sequencer;
    logic       clk;
    logic       rst_n;
    logic       abort;
    logic       conv_valid;
    logic       conv_done;
    logic       conv_rst;
    logic       conv_start;
    logic [15:0] bcfg1;
    logic [15:0] bcfg2;
    logic [15:0] cprm1;
    logic [4:0] bank;
    logic       gdone;
    logic       ldone;
    logic       err;

    int errors = 0;
    int checks = 0;
    int n_accept = 0;
    int n_gdone = 0;
    int n_ldone = 0;
    int snap_g;
    int snap_l;
    int snap_a;

    conv_layer_sequencer_if #(.MaxFilters(64)) cmd_if ();

    conv_layer_sequencer #(
        .EngineCount   (2),
        .KernelSize    (3),
        .MaxMatrixSize (10),
        .MaxFilters    (64)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd           (cmd_if),
        .abort_i       (abort),
        .conv_rst_o    (conv_rst),
        .conv_start_o  (conv_start),
        .reg_bcfg1_o   (bcfg1),
        .reg_bcfg2_o   (bcfg2),
        .reg_cprm1_o   (cprm1),
        .weight_bank_o (bank),
        .conv_valid_i  (conv_valid),
        .conv_done_i   (conv_done),
        .group_done_o  (gdone),
        .layer_done_o  (ldone),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cmd_if.cmd_valid_i && cmd_if.cmd_ready_o) n_accept++;
        if (gdone) n_gdone++;
        if (ldone) n_ldone++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge, i.e. in the RST cycle.
    task automatic send_cmd(input logic [15:0] m, input logic [6:0] f, input logic [1:0] s,
                            input logic [3:0] sh, input bit keep);
        bit done;
        done = 1'b0;
        cmd_if.cmd_matrix_size_i = m;
        cmd_if.cmd_filters_i     = f;
        cmd_if.cmd_stride_log2_i = s;
        cmd_if.cmd_shift_i       = sh;
        cmd_if.cmd_valid_i       = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready_o) done = 1'b1;
        end
        if (!done) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_if.cmd_valid_i = 1'b0;
        end else begin
            tick();
            if (!keep) cmd_if.cmd_valid_i = 1'b0;
        end
    endtask

    // Called in the RST cycle; leaves the bench in the first RUN cycle.
    task automatic group_entry(input string tag, input logic [4:0] exp_bank, input logic [15:0] exp_bcfg1);
        check({tag, "_rst"}, 32'(conv_rst), 32'd1);
        check({tag, "_bank"}, 32'(bank), 32'(exp_bank));
        check({tag, "_bcfg1"}, 32'(bcfg1), 32'(exp_bcfg1));
        tick();
        check({tag, "_start"}, 32'(conv_start), 32'd1);
        tick();
    endtask

    task automatic next_group(input string tag, input logic [4:0] exp_bank, input logic [15:0] exp_bcfg1);
        tick();
        group_entry(tag, exp_bank, exp_bcfg1);
    endtask

    // Emits nbeats beats then done; returns in the CHECK cycle.
    task automatic run_group(input int nbeats, input bit coinc);
        for (int i = 0; i < nbeats; i++) begin
            conv_valid = 1'b1;
            conv_done  = coinc && (i == nbeats - 1);
            tick();
        end
        conv_valid = 1'b0;
        conv_done  = 1'b0;
        if (!coinc) begin
            conv_done = 1'b1;
            tick();
            conv_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        abort = 1'b0;
        conv_valid = 1'b0;
        conv_done = 1'b0;
        cmd_if.cmd_valid_i = 1'b0;
        cmd_if.cmd_matrix_size_i = '0;
        cmd_if.cmd_filters_i = '0;
        cmd_if.cmd_stride_log2_i = '0;
        cmd_if.cmd_shift_i = '0;
        repeat (2) tick();
        check("rst_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        check("rst_outs", {conv_rst, conv_start, gdone, ldone, err}, 32'd0);
        check("rst_regs", {bcfg1, bcfg2}, 32'd0);
        check("rst_bank", 32'(bank), 32'd0);
        rst_n = 1'b1;
        tick();

        // Done while idle is ignored.
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        check("idle_done_gdone", 32'(gdone), 32'd0);
        check("idle_done_ready", 32'(cmd_if.cmd_ready_o), 32'd1);

        // 1: single group, M=5 F=2 S=1, N=9.
        send_cmd(16'd5, 7'd2, 2'd0, 4'd0, 1'b0);
        group_entry("t1", 5'd0, 16'h0002);
        check("t1_bcfg2", 32'(bcfg2), 32'h0005);
        check("t1_cprm1", 32'(cprm1), 32'h0040);
        run_group(9, 1'b0);
        check("t1_gdone", 32'(gdone), 32'd1);
        check("t1_ldone", 32'(ldone), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        tick();
        check("t1_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        check("t1_ldone_pulse", 32'(ldone), 32'd0);

        // 2: F=5 -> three groups, engines 2,2,1, shift 3.
        snap_g = n_gdone;
        snap_l = n_ldone;
        send_cmd(16'd5, 7'd5, 2'd0, 4'd3, 1'b0);
        group_entry("t2g0", 5'd0, 16'h0302);
        run_group(9, 1'b0);
        check("t2g0_ldone", 32'(ldone), 32'd0);
        next_group("t2g1", 5'd1, 16'h0302);
        run_group(9, 1'b0);
        check("t2g1_ldone", 32'(ldone), 32'd0);
        next_group("t2g2", 5'd2, 16'h0301);
        run_group(9, 1'b0);
        check("t2g2_ldone", 32'(ldone), 32'd1);
        tick();
        check("t2_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        check("t2_gdone_cnt", 32'(n_gdone - snap_g), 32'd3);
        check("t2_ldone_cnt", 32'(n_ldone - snap_l), 32'd1);
        check("t2_err", 32'(err), 32'd0);

        // 3: M=9 S=2 -> N=16; only 15 beats sets err, next command clears it.
        send_cmd(16'd9, 7'd2, 2'd1, 4'd0, 1'b0);
        group_entry("t3", 5'd0, 16'h0002);
        check("t3_cprm1", 32'(cprm1), 32'h0080);
        check("t3_bcfg2", 32'(bcfg2), 32'h0009);
        run_group(15, 1'b0);
        check("t3_err_check", 32'(err), 32'd1);
        tick();
        check("t3_err_sticky", 32'(err), 32'd1);
        send_cmd(16'd5, 7'd2, 2'd0, 4'd0, 1'b0);
        check("t3_err_cleared", 32'(err), 32'd0);
        group_entry("t3b", 5'd0, 16'h0002);
        run_group(9, 1'b0);
        check("t3b_err", 32'(err), 32'd0);
        tick();

        // 4: abort in RUN of group 1 of 3; err from group 0 survives.
        snap_l = n_ldone;
        send_cmd(16'd5, 7'd5, 2'd0, 4'd0, 1'b0);
        group_entry("t4g0", 5'd0, 16'h0002);
        run_group(8, 1'b0);
        check("t4g0_err", 32'(err), 32'd1);
        next_group("t4g1", 5'd1, 16'h0002);
        conv_valid = 1'b1;
        repeat (2) tick();
        conv_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_rst", 32'(conv_rst), 32'd1);
        check("t4_abort_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        check("t4_abort_dones", {gdone, ldone}, 32'd0);
        check("t4_abort_err", 32'(err), 32'd1);
        tick();
        check("t4_rst_one_cycle", 32'(conv_rst), 32'd0);
        check("t4_ldone_cnt", 32'(n_ldone - snap_l), 32'd0);
        send_cmd(16'd5, 7'd5, 2'd0, 4'd0, 1'b0);
        check("t4_err_cleared", 32'(err), 32'd0);
        group_entry("t4r", 5'd0, 16'h0002);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4r_abort_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        tick();

        // 5: asynchronous reset while running.
        send_cmd(16'd5, 7'd2, 2'd0, 4'd0, 1'b0);
        group_entry("t5", 5'd0, 16'h0002);
        conv_valid = 1'b1;
        tick();
        check("t5_busy", 32'(cmd_if.cmd_ready_o), 32'd0);
        #3;
        rst_n = 1'b0;
        conv_valid = 1'b0;
        #1;
        check("t5_async_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        check("t5_async_regs", {bcfg1, bcfg2}, 32'd0);
        check("t5_async_outs", {conv_rst, conv_start, gdone, ldone, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_ready_after", 32'(cmd_if.cmd_ready_o), 32'd1);
        check("t5_rst_after", 32'(conv_rst), 32'd0);

        // 6: last beat coincident with done; cmd_valid held through the layer.
        snap_a = n_accept;
        send_cmd(16'd5, 7'd2, 2'd0, 4'd0, 1'b1);
        group_entry("t6", 5'd0, 16'h0002);
        run_group(9, 1'b1);
        check("t6_gdone", 32'(gdone), 32'd1);
        check("t6_ldone", 32'(ldone), 32'd1);
        check("t6_err", 32'(err), 32'd0);
        cmd_if.cmd_valid_i = 1'b0;
        tick();
        check("t6_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
        tick();
        check("t6_no_reaccept_rst", 32'(conv_rst), 32'd0);
        check("t6_accept_cnt", 32'(n_accept - snap_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
